fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 clk  in  1  clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 stall_ID  in  1  hazard stall from ID: hold IF/ID register contents.
REQ-005 redirect  in  1  branch/jump taken, resolved in ID.
REQ-006 redirect_pc  in  16  redirect target; bit 0 forced to 0 internally.
REQ-007 halt_ID  in  1  HALT decoded in ID.
REQ-008 imem_req  out  1  instruction memory request.
REQ-009 imem_addr  out  16  fetch address; equals PC register.
REQ-010 imem_rdata  in  16  instruction word, valid only when imem_done=1.
REQ-011 imem_done  in  1  one-cycle completion strobe, only while imem_req=1.
REQ-012 instr_IF_ID  out  16  IF/ID instruction; NOP (0x0800) when invalid.
REQ-013 pc_plus2_IF_ID  out  16  fetch address + 2 of instr_IF_ID.
REQ-014 valid_IF_ID  out  1  instr_IF_ID holds a real instruction.
REQ-015 fetch_halted  out  1  high in HALTED state.

Function
REQ-016 The block SHALL implement states FETCH, BUFFER, DRAIN and HALTED.
REQ-017 imem_req SHALL be 1 in FETCH and DRAIN and 0 in BUFFER and HALTED (Moore output).
REQ-018 imem_addr SHALL remain stable while imem_req=1 until imem_done is sampled.
REQ-019 PC arithmetic SHALL be 16-bit modulo: 0xFFFE+2 = 0x0000.
REQ-020 Event priority each cycle SHALL be redirect > halt_ID > stall_ID; halt_ID is acted on only when stall_ID=0.
REQ-021 FETCH, done, no redirect/halt, stall_ID=0: IF/ID <= {imem_rdata, PC+2, valid=1}, PC <= PC+2, stay FETCH; next request issues in the following cycle (1 instruction/cycle when done is returned every cycle).
REQ-022 FETCH, done, stall_ID=1: word and PC+2 go to the skid buffer, PC <= PC+2, IF/ID held, go BUFFER.
REQ-023 FETCH, no done, stall_ID=0: IF/ID <= bubble (NOP, valid=0); stall_ID=1: IF/ID held.
REQ-024 FETCH, redirect, done: data discarded, PC <= redirect_pc, IF/ID <= bubble, stay FETCH.
REQ-025 FETCH, redirect, no done: target saved, IF/ID <= bubble, go DRAIN with kill-to-FETCH.
REQ-026 FETCH, halt_ID, done: data discarded, go HALTED; halt_ID, no done: go DRAIN with kill-to-HALTED.
REQ-027 BUFFER, stall_ID=1: hold everything; stall_ID=0: IF/ID <= buffer (valid=1), go FETCH.
REQ-028 BUFFER, redirect: buffer discarded, PC <= redirect_pc, IF/ID <= bubble, go FETCH; halt_ID: buffer discarded, go HALTED.
REQ-029 DRAIN: keep old address and request until imem_done, then discard data and load PC from the saved target (to FETCH) or go HALTED; IF/ID <= bubble each unstalled cycle.
REQ-030 DRAIN, new redirect: saved target overwritten with the newest redirect_pc, and the kill target becomes FETCH.
REQ-031 HALTED SHALL be left only by reset; all inputs are ignored and IF/ID <= bubble.
REQ-032 IF/ID outputs SHALL be registered, and no output SHALL depend combinationally on imem_rdata.

Reset
REQ-033 While rst_n=0, the block SHALL hold: PC=0x0000, state FETCH, imem_req=0, instr_IF_ID=0x0800, pc_plus2_IF_ID=0x0000, valid_IF_ID=0, fetch_halted=0, and the buffer and saved target cleared.
REQ-034 Assertion of rst_n mid-request SHALL abandon that request.
REQ-035 The first request SHALL issue at address 0x0000 in the first cycle after rst_n deasserts.

Verification
REQ-036 Reset release, done every cycle with words 0x1111,0x2222,0x3333 -> imem_addr 0x0000,0x0002,0x0004 in consecutive cycles; IF/ID shows each word one cycle after its done, with pc_plus2 0x0002,0x0004,0x0006.
REQ-037 stall_ID=1 for 3 cycles, asserted in the same cycle as done for 0x2222 -> IF/ID holds 0x1111, imem_req=0, and 0x2222 appears in IF/ID the cycle after stall_ID falls.
REQ-038 Redirect to 0x0041 while a request to 0x0010 is pending, done 2 cycles later -> returned data dropped, valid_IF_ID=0, next request to 0x0040.
REQ-039 Redirect and done in the same cycle, redirect_pc=0x0100 -> data dropped, next imem_addr=0x0100, no stall of the request stream.
REQ-040 halt_ID with request pending -> request completes and is dropped, fetch_halted=1, imem_req=0 thereafter; later redirect ignored; rst_n pulse -> fetch restarts at 0x0000.
REQ-041 PC=0xFFFE with done -> pc_plus2_IF_ID=0x0000, next imem_addr=0x0000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- instruction-memory request/response bundle.
//
// Connects the fetch unit (master) to an instruction memory (slave).
//   imem_req   : request, held high until imem_done is sampled
//   imem_addr  : halfword-aligned fetch address, stable while imem_req=1
//   imem_rdata : instruction word, meaningful only while imem_done=1
//   imem_done  : one-cycle completion strobe, only while imem_req=1
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_done;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_done
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_done
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with IF/ID pipeline register.
//
// Issues one request at a time to instruction memory and feeds the IF/ID
// register. A one-entry skid buffer catches a word that completes while ID
// is stalled. A redirect or halt arriving while a request is still pending
// moves to DRAIN, which lets that request finish and throws the data away
// before taking the redirect target or halting.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   imem            : instruction memory bus (master side)
//   stall_ID        : hold the IF/ID register
//   redirect        : taken branch/jump resolved in ID
//   redirect_pc     : redirect target (bit 0 ignored)
//   halt_ID         : HALT decoded in ID
//   instr_IF_ID     : IF/ID instruction, NOP (0x0800) when invalid
//   pc_plus2_IF_ID  : fetch address + 2 of instr_IF_ID (0 for bubbles)
//   valid_IF_ID     : IF/ID holds a real instruction
//   fetch_halted    : fetch unit is halted
module fetch_unit (
    input  logic              clk,
    input  logic              rst_n,
    fetch_unit_if.master      imem,
    input  logic              stall_ID,
    input  logic              redirect,
    input  logic [15:0]       redirect_pc,
    input  logic              halt_ID,
    output logic [15:0]       instr_IF_ID,
    output logic [15:0]       pc_plus2_IF_ID,
    output logic              valid_IF_ID,
    output logic              fetch_halted
);
    localparam logic [15:0] NOP = 16'h0800;

    typedef enum logic [1:0] {S_FETCH, S_BUFFER, S_DRAIN, S_HALTED} state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc2_q, pc2_d;
    logic        valid_q, valid_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc2_q, buf_pc2_d;
    logic [15:0] target_q, target_d;
    // In DRAIN: 1 = halt once the pending request completes, 0 = go to target_q.
    logic        kill_halt_q, kill_halt_d;

    logic [15:0] redirect_tgt;
    logic [15:0] pc_inc;
    logic        halt_act;
    logic        drain_halt;

    assign redirect_tgt = {redirect_pc[15:1], 1'b0};
    assign pc_inc       = pc_q + 16'd2;
    assign halt_act     = halt_ID && !stall_ID;
    assign drain_halt   = kill_halt_q || halt_act;

    // Moore request; the rst_n term keeps the request low throughout reset
    // while still allowing the first request in the cycle reset is released.
    assign imem.imem_req  = rst_n && ((state_q == S_FETCH) || (state_q == S_DRAIN));
    assign imem.imem_addr = pc_q;

    assign instr_IF_ID    = instr_q;
    assign pc_plus2_IF_ID = pc2_q;
    assign valid_IF_ID    = valid_q;
    assign fetch_halted   = (state_q == S_HALTED);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        pc2_d       = pc2_q;
        valid_d     = valid_q;
        buf_instr_d = buf_instr_q;
        buf_pc2_d   = buf_pc2_q;
        target_d    = target_q;
        kill_halt_d = kill_halt_q;

        case (state_q)
            S_FETCH: begin
                if (redirect) begin
                    {instr_d, pc2_d, valid_d} = {NOP, 16'h0000, 1'b0};
                    if (imem.imem_done) begin
                        pc_d = redirect_tgt;
                    end else begin
                        target_d    = redirect_tgt;
                        kill_halt_d = 1'b0;
                        state_d     = S_DRAIN;
                    end
                end else if (halt_act) begin
                    {instr_d, pc2_d, valid_d} = {NOP, 16'h0000, 1'b0};
                    kill_halt_d = 1'b1;
                    state_d     = imem.imem_done ? S_HALTED : S_DRAIN;
                end else if (imem.imem_done) begin
                    pc_d = pc_inc;
                    if (stall_ID) begin
                        buf_instr_d = imem.imem_rdata;
                        buf_pc2_d   = pc_inc;
                        state_d     = S_BUFFER;
                    end else begin
                        {instr_d, pc2_d, valid_d} = {imem.imem_rdata, pc_inc, 1'b1};
                    end
                end else if (!stall_ID) begin
                    {instr_d, pc2_d, valid_d} = {NOP, 16'h0000, 1'b0};
                end
            end
            S_BUFFER: begin
                // No request is outstanding here, so a redirect applies at once.
                if (redirect) begin
                    {instr_d, pc2_d, valid_d} = {NOP, 16'h0000, 1'b0};
                    pc_d    = redirect_tgt;
                    state_d = S_FETCH;
                end else if (halt_act) begin
                    {instr_d, pc2_d, valid_d} = {NOP, 16'h0000, 1'b0};
                    state_d = S_HALTED;
                end else if (!stall_ID) begin
                    {instr_d, pc2_d, valid_d} = {buf_instr_q, buf_pc2_q, 1'b1};
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    // The newest redirect wins, even over one already saved.
                    {instr_d, pc2_d, valid_d} = {NOP, 16'h0000, 1'b0};
                    if (imem.imem_done) begin
                        pc_d    = redirect_tgt;
                        state_d = S_FETCH;
                    end else begin
                        target_d    = redirect_tgt;
                        kill_halt_d = 1'b0;
                    end
                end else begin
                    if (!stall_ID) begin
                        {instr_d, pc2_d, valid_d} = {NOP, 16'h0000, 1'b0};
                    end
                    if (imem.imem_done) begin
                        if (drain_halt) begin
                            state_d = S_HALTED;
                        end else begin
                            pc_d    = target_q;
                            state_d = S_FETCH;
                        end
                    end else begin
                        kill_halt_d = drain_halt;
                    end
                end
            end
            S_HALTED: begin
                {instr_d, pc2_d, valid_d} = {NOP, 16'h0000, 1'b0};
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            pc_q        <= 16'h0000;
            instr_q     <= NOP;
            pc2_q       <= 16'h0000;
            valid_q     <= 1'b0;
            buf_instr_q <= 16'h0000;
            buf_pc2_q   <= 16'h0000;
            target_q    <= 16'h0000;
            kill_halt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            pc2_q       <= pc2_d;
            valid_q     <= valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc2_q   <= buf_pc2_d;
            target_q    <= target_d;
            kill_halt_q <= kill_halt_d;
        end
    end
endmodule
